// File: rtl/regfile_seq_pkg.sv
// ---------------------------------------------------------------------------
// regfile_seq_pkg
// Shared definitions for the multicycle register-file sequencer:
//   - state_t   : controller state encoding (IDLE, T1, T2, T3)
//   - opcode_t  : instruction opcodes (1000-1111 are illegal)
//   - instruction field positions inside the 10-bit instruction word
//   - isAluOp() : true for opcodes that take the three-step ALU path
// ---------------------------------------------------------------------------
package regfile_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

   typedef enum logic [3:0] {
      OP_LOAD = 4'd0,
      OP_MOV  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_INV  = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7
   } opcode_t;

   localparam int OP_MSB = 9;
   localparam int OP_LSB = 6;
   localparam int RX_MSB = 5;
   localparam int RX_LSB = 4;
   localparam int RY_MSB = 3;
   localparam int RY_LSB = 2;

   // ADD through XOR share the read-Rx / compute / write-back sequence.
   function automatic logic isAluOp(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/regfile_seq_decode.sv
// ---------------------------------------------------------------------------
// regfile_seq_decode
// Purely combinational decode of (state, latched instruction fields) into
// the register-file, ALU and bus control strobes.
// Ports:
//   i_state   : current controller state
//   i_opcode  : latched opcode, i_rx / i_ry : latched register fields
//   o_enw/o_wra, o_enr0/o_rda0, o_enr1/o_rda1 : register file controls
//   o_ain, o_gin, o_gout, o_extern, o_alucont  : ALU latch / bus controls
//   o_done    : last cycle of an instruction, o_busy : state is not IDLE
// ---------------------------------------------------------------------------
module regfile_seq_decode
   import regfile_seq_pkg::*;
#(
   parameter int AW = 2
) (
   input  state_t        i_state,
   input  logic [3:0]    i_opcode,
   input  logic [AW-1:0] i_rx,
   input  logic [AW-1:0] i_ry,
   output logic          o_enw,
   output logic [AW-1:0] o_wra,
   output logic          o_enr0,
   output logic [AW-1:0] o_rda0,
   output logic          o_enr1,
   output logic [AW-1:0] o_rda1,
   output logic          o_ain,
   output logic          o_gin,
   output logic          o_gout,
   output logic          o_extern,
   output logic [3:0]    o_alucont,
   output logic          o_done,
   output logic          o_busy
);

   // Everything defaults to inactive with zero addresses so unused address
   // outputs never carry stale register numbers. T2/T3 are only reachable
   // for ALU opcodes, so they need no opcode guard beyond the INV case.
   always_comb begin
      o_enw     = 1'b0;
      o_wra     = '0;
      o_enr0    = 1'b0;
      o_rda0    = '0;
      o_enr1    = 1'b0;
      o_rda1    = '0;
      o_ain     = 1'b0;
      o_gin     = 1'b0;
      o_gout    = 1'b0;
      o_extern  = 1'b0;
      o_alucont = 4'd0;
      o_done    = 1'b0;
      o_busy    = (i_state != IDLE);
      case (i_state)
         T1: begin
            if (i_opcode == OP_LOAD) begin
               o_extern = 1'b1;
               o_enw    = 1'b1;
               o_wra    = i_rx;
               o_done   = 1'b1;
            end else if (i_opcode == OP_MOV) begin
               o_enr0 = 1'b1;
               o_rda0 = i_ry;
               o_enw  = 1'b1;
               o_wra  = i_rx;
               o_done = 1'b1;
            end else if (isAluOp(i_opcode)) begin
               o_enr0 = 1'b1;
               o_rda0 = i_rx;
               o_ain  = 1'b1;
            end else begin
               o_done = 1'b1;
            end
         end
         T2: begin
            if (i_opcode != OP_INV) begin
               o_enr1 = 1'b1;
               o_rda1 = i_ry;
            end
            o_alucont = i_opcode;
            o_gin     = 1'b1;
         end
         T3: begin
            o_gout = 1'b1;
            o_enw  = 1'b1;
            o_wra  = i_rx;
            o_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/regfile_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_sequencer
// Multicycle control unit for the 10-bit datapath. Latches one instruction
// per accepted Exec and walks IDLE -> T1 [-> T2 -> T3] -> IDLE, driving the
// register file, ALU latches and shared-bus drivers through the decoder.
// Ports:
//   CLKb, Rst        : clock (rising edge), async active-high reset
//   Exec, Instr      : start request (accepted in IDLE only), instruction
//   ENW/WRA, ENR0/RDA0, ENR1/RDA1 : register file controls
//   Ain, Gin, Gout, Extern, ALUcont : ALU latch and bus controls
//   Done, Busy       : final instruction cycle, not-IDLE indicator
// Optional build macro REGFILE_PEEK_EN adds PeekEn/PeekAddr/PeekGrant so a
// debug display can read a register through port 1 while the unit is idle.
// ---------------------------------------------------------------------------
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int DW = 10,
   parameter int AW = 2
) (
   input  logic          CLKb,
   input  logic          Rst,
   input  logic          Exec,
   input  logic [DW-1:0] Instr,
   output logic          ENW,
   output logic [AW-1:0] WRA,
   output logic          ENR0,
   output logic [AW-1:0] RDA0,
   output logic          ENR1,
   output logic [AW-1:0] RDA1,
   output logic          Ain,
   output logic          Gin,
   output logic          Gout,
   output logic          Extern,
   output logic [3:0]    ALUcont,
   output logic          Done,
`ifdef REGFILE_PEEK_EN
   input  logic          PeekEn,
   input  logic [AW-1:0] PeekAddr,
   output logic          PeekGrant,
`endif
   output logic          Busy
);

   state_t        r_state;
   state_t        w_nextState;
   logic [DW-1:0] r_ir;
   logic          w_accept;
   logic          w_decEnr1;
   logic [AW-1:0] w_decRda1;
   logic          w_unusedIrBits;

   assign w_accept       = (r_state == IDLE) && Exec;
   assign w_unusedIrBits = ^r_ir[1:0];

   // Next-state logic: only ALU opcodes continue past T1.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    w_nextState = Exec ? T1 : IDLE;
         T1:      w_nextState = isAluOp(r_ir[OP_MSB:OP_LSB]) ? T2 : IDLE;
         T2:      w_nextState = T3;
         T3:      w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // State and instruction registers. The IR only loads on an accepted
   // Exec, so requests arriving mid-instruction cannot disturb it.
   always_ff @(posedge CLKb or posedge Rst) begin
      if (Rst) begin
         r_state <= IDLE;
         r_ir    <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_ir <= Instr;
         end
      end
   end

   regfile_seq_decode #(.AW(AW)) u_decode (
      .i_state   (r_state),
      .i_opcode  (r_ir[OP_MSB:OP_LSB]),
      .i_rx      (r_ir[RX_MSB:RX_LSB]),
      .i_ry      (r_ir[RY_MSB:RY_LSB]),
      .o_enw     (ENW),
      .o_wra     (WRA),
      .o_enr0    (ENR0),
      .o_rda0    (RDA0),
      .o_enr1    (w_decEnr1),
      .o_rda1    (w_decRda1),
      .o_ain     (Ain),
      .o_gin     (Gin),
      .o_gout    (Gout),
      .o_extern  (Extern),
      .o_alucont (ALUcont),
      .o_done    (Done),
      .o_busy    (Busy)
   );

`ifdef REGFILE_PEEK_EN
   // Port 1 is lent to the debug reader only while idle and not about to
   // start an instruction, so the controller always owns it once Busy.
   logic w_peek;
   assign w_peek    = (r_state == IDLE) && PeekEn && !Exec;
   assign PeekGrant = w_peek;
   assign ENR1      = w_decEnr1 | w_peek;
   assign RDA1      = w_peek ? PeekAddr : w_decRda1;
`else
   assign ENR1 = w_decEnr1;
   assign RDA1 = w_decRda1;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_sequencer
// Directed self-checking bench for regfile_sequencer. Output fields are
// packed as {ENW,WRA,ENR0,RDA0,ENR1,RDA1,Ain,Gin,Gout,Extern,ALUcont,
// Done,Busy}; expected vectors are written by hand with mk().
// ---------------------------------------------------------------------------
module tb_regfile_sequencer;

   logic       CLKb;
   logic       Rst;
   logic       Exec;
   logic [9:0] Instr;
   logic       ENW;
   logic [1:0] WRA;
   logic       ENR0;
   logic [1:0] RDA0;
   logic       ENR1;
   logic [1:0] RDA1;
   logic       Ain;
   logic       Gin;
   logic       Gout;
   logic       Extern;
   logic [3:0] ALUcont;
   logic       Done;
   logic       Busy;
`ifdef REGFILE_PEEK_EN
   logic       PeekEn;
   logic [1:0] PeekAddr;
   logic       PeekGrant;
`endif

   int checks = 0;
   int errors = 0;

   regfile_sequencer #(.DW(10), .AW(2)) dut (
      .CLKb      (CLKb),
      .Rst       (Rst),
      .Exec      (Exec),
      .Instr     (Instr),
      .ENW       (ENW),
      .WRA       (WRA),
      .ENR0      (ENR0),
      .RDA0      (RDA0),
      .ENR1      (ENR1),
      .RDA1      (RDA1),
      .Ain       (Ain),
      .Gin       (Gin),
      .Gout      (Gout),
      .Extern    (Extern),
      .ALUcont   (ALUcont),
      .Done      (Done),
`ifdef REGFILE_PEEK_EN
      .PeekEn    (PeekEn),
      .PeekAddr  (PeekAddr),
      .PeekGrant (PeekGrant),
`endif
      .Busy      (Busy)
   );

   // Free-running clock, period 10.
   initial begin
      CLKb = 1'b0;
      forever #5 CLKb = ~CLKb;
   end

   logic [18:0] obs;
   assign obs = {ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout, Extern,
                 ALUcont, Done, Busy};

   localparam logic [18:0] ZERO = 19'd0;

   function automatic logic [18:0] mk(
      input logic enw, input logic [1:0] wra,
      input logic enr0, input logic [1:0] rda0,
      input logic enr1, input logic [1:0] rda1,
      input logic ain, input logic gin, input logic gout, input logic ext,
      input logic [3:0] alu, input logic done, input logic busy);
      return {enw, wra, enr0, rda0, enr1, rda1, ain, gin, gout, ext,
              alu, done, busy};
   endfunction

   // Advance one clock and settle just after the rising edge.
   task automatic applyStimulus();
      @(posedge CLKb);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [18:0] expected);
      checks++;
      assert (obs === expected) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expected);
      end
   endtask

   // Bus drivers must be mutually exclusive and writes happen only in Done.
   always @(negedge CLKb) begin
      checks++;
      assert (((32'(ENR0) + 32'(Extern) + 32'(Gout)) <= 1) && (!ENW || Done))
      else begin
         errors++;
         $error("FAIL bus_excl observed=%b%b%b enw=%b done=%b expected=onehot0",
                ENR0, Extern, Gout, ENW, Done);
      end
   end

   initial begin
      Rst   = 1'b1;
      Exec  = 1'b1;
      Instr = 10'b0000_01_00_00;
`ifdef REGFILE_PEEK_EN
      PeekEn   = 1'b0;
      PeekAddr = 2'd0;
`endif
      // Reset with Exec asserted: nothing may happen.
      applyStimulus();
      applyStimulus();
      checkOutput("reset", ZERO);

      // LOAD R1, Exec held high: Done, IDLE, T1 repeating.
      Rst = 1'b0;
      applyStimulus();
      checkOutput("load_t1", mk(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 1, 1));
      applyStimulus();
      checkOutput("load_idle_gap", ZERO);
      applyStimulus();
      checkOutput("load_reexec", mk(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 1, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("load_done_idle", ZERO);

      // ADD R2,R3
      Instr = 10'b0010_10_11_00;
      Exec  = 1'b1;
      applyStimulus();
      checkOutput("add_t1", mk(0, 0, 1, 2'd2, 0, 0, 1, 0, 0, 0, 4'd0, 0, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("add_t2", mk(0, 0, 0, 0, 1, 2'd3, 0, 1, 0, 0, 4'd2, 0, 1));
      applyStimulus();
      checkOutput("add_t3", mk(1, 2'd2, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 1, 1));
      applyStimulus();
      checkOutput("add_idle", ZERO);

      // INV R3: port 1 stays unused in T2
      Instr = 10'b0100_11_00_00;
      Exec  = 1'b1;
      applyStimulus();
      checkOutput("inv_t1", mk(0, 0, 1, 2'd3, 0, 0, 1, 0, 0, 0, 4'd0, 0, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("inv_t2", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd4, 0, 1));
      applyStimulus();
      checkOutput("inv_t3", mk(1, 2'd3, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 1, 1));
      applyStimulus();
      checkOutput("inv_idle", ZERO);

      // SUB R1,R2 with a competing Exec/Instr during T2
      Instr = 10'b0011_01_10_00;
      Exec  = 1'b1;
      applyStimulus();
      checkOutput("sub_t1", mk(0, 0, 1, 2'd1, 0, 0, 1, 0, 0, 0, 4'd0, 0, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("sub_t2", mk(0, 0, 0, 0, 1, 2'd2, 0, 1, 0, 0, 4'd3, 0, 1));
      Instr = 10'b0000_11_00_00;
      Exec  = 1'b1;
      applyStimulus();
      checkOutput("sub_t3_ir_kept", mk(1, 2'd1, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 1, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("sub_idle", ZERO);

      // Illegal opcode 1010: single Done cycle, no enables
      Instr = 10'b1010_01_01_00;
      Exec  = 1'b1;
      applyStimulus();
      checkOutput("illegal_t1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("illegal_idle", ZERO);

      // XOR R2,R1 aborted by reset during T2
      Instr = 10'b0111_10_01_00;
      Exec  = 1'b1;
      applyStimulus();
      checkOutput("xor_t1", mk(0, 0, 1, 2'd2, 0, 0, 1, 0, 0, 0, 4'd0, 0, 1));
      Exec = 1'b0;
      applyStimulus();
      checkOutput("xor_t2", mk(0, 0, 0, 0, 1, 2'd1, 0, 1, 0, 0, 4'd7, 0, 1));
      #2;
      Rst = 1'b1;
      #1;
      checkOutput("rst_mid_async", ZERO);
      applyStimulus();
      Rst = 1'b0;
      checkOutput("rst_mid_held", ZERO);
      applyStimulus();
      checkOutput("rst_no_write", ZERO);
      applyStimulus();
      checkOutput("rst_still_idle", ZERO);

`ifdef REGFILE_PEEK_EN
      // Debug read through port 1 while idle
      PeekEn   = 1'b1;
      PeekAddr = 2'd2;
      #1;
      checkOutput("peek_idle", mk(0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 4'd0, 0, 0));
      checks++;
      assert (PeekGrant === 1'b1) else begin
         errors++;
         $error("FAIL peek_grant observed=%b expected=1", PeekGrant);
      end
      Instr = 10'b0000_00_00_00;
      Exec  = 1'b1;
      #1;
      checks++;
      assert (PeekGrant === 1'b0) else begin
         errors++;
         $error("FAIL peek_accept_grant observed=%b expected=0", PeekGrant);
      end
      applyStimulus();
      checkOutput("peek_busy_load", mk(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 1, 1));
      checks++;
      assert (PeekGrant === 1'b0) else begin
         errors++;
         $error("FAIL peek_busy_grant observed=%b expected=0", PeekGrant);
      end
      Exec = 1'b0;
      applyStimulus();
      checkOutput("peek_back", mk(0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 4'd0, 0, 0));
      PeekEn = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
